half_div_meter: RTL and testbench
=================================

Name: half_div_meter

Overview:
- Measures a divided clock `clk_div` generated from `clk_in`. This includes N+0.5 ratios from the fractional divider.
- Reports the period and high time in half-cycles of `clk_in`, so 5.5 divide reads as 11.
- Used on the receiving side of divider outputs, for ratio checking, lock indication and stall detection.
- `clk_div` is synchronous to `clk_in` (derived from it), so no synchronizer is used.

Parameters:
- W, 8, width of the half-cycle counters and result outputs.
- LOCK_CNT, 4, consecutive identical period measurements required to assert `locked` (range 1..15).
- TIMEOUT, 200, half-cycles without a rising edge before `stalled` asserts; must be < 2^W-2.

Ports:
- clk_in  input  1  reference clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clk_div  input  1  divided clock under measurement.
- ratio_x2  output  W  last measured period, in clk_in half-cycles.
- high_x2  output  W  last measured high time, in clk_in half-cycles.
- meas_valid  output  1  one-cycle pulse: `ratio_x2`/`high_x2` updated.
- locked  output  1  period stable for LOCK_CNT consecutive measurements.
- stalled  output  1  no rising edge for ≥ TIMEOUT half-cycles.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; internal samples 0; `cnt`=0; `armed`=0; match counter 0.
- Sampling:
  - `s_neg` captures `clk_div` on negedge `clk_in`.
  - `s_pos` captures `clk_div` on posedge `clk_in`.
  - At each posedge, the ordered half-sample triple is p (previous `s_pos`), a (`s_neg`, older), b (`s_pos`, newer).
  - All remaining logic is posedge `clk_in` only.
- Edge detect:
  - Rise at a: p=0,a=1. Rise at b: a=0,b=1. Both cannot occur in one cycle.
  - Fall at a and fall at b are defined likewise.
- Counter `cnt` = half-samples since the rising-edge sample.
  - Rise at a: period = cnt+1, cnt←1.
  - Rise at b: period = cnt+2, cnt←0.
  - No rise: cnt←cnt+2, saturating at 2^W-1.
- High time, measured from the last rise:
  - Fall at a: high = cnt+1. Fall at b: high = cnt+2. The result is held in `high_hold`.
  - If a fall and a rise occur in the same cycle, the fall is evaluated with the pre-update `cnt`.
- Measurement on a rise:
  - If `armed`=1: on the next posedge, `ratio_x2`←period, `high_x2`←`high_hold`, and `meas_valid` pulses for 1 cycle.
  - Latency is one `clk_in` cycle after the posedge that registered the rising sample.
  - If `armed`=0 (first rise after reset or after a stall): no output update, no pulse, then set `armed`←1.
- Lock logic, evaluated on each valid measurement:
  - If period == previous `ratio_x2` and the previous measurement was valid, the match counter increments, saturating at LOCK_CNT-1. Otherwise it resets to 0.
  - `locked`=1 once the counter reaches LOCK_CNT-1, i.e. after LOCK_CNT equal periods including the first. Exception: LOCK_CNT=1 locks on the first valid measurement.
  - Mismatch: `locked`←0 in the same cycle `meas_valid` pulses.
- Stall:
  - When `cnt` ≥ TIMEOUT: `stalled`←1, `locked`←0, `armed`←0, match counter←0.
  - `ratio_x2`/`high_x2` retain their last values.
  - `stalled` clears on the next rising edge. That edge re-arms only; it produces no measurement.
- Static `clk_div` (stuck high or low) is handled as a stall.
- Minimum measurable period is 2 (divide-by-1, `clk_div`=~`clk_in`-like). Period 1 is impossible by construction.
- Reset mid-measurement: everything aborts immediately; the first post-reset rise only arms.

Test Plan:
- Divide 5.5: bench drives `clk_div` with period 11 half-cycles, high 2 half-cycles, for 8 periods.
  - No `meas_valid` on the first rise.
  - Then `ratio_x2`=11, `high_x2`=2 on every pulse.
  - `locked`=1 after the 4th valid measurement.
- Divide 4, 50% duty: `ratio_x2`=8, `high_x2`=4; `meas_valid` spaced 4 cycles apart; `locked` asserts.
- Divide 1 (`clk_div` toggling every half-cycle): `ratio_x2`=2, `high_x2`=1, `locked` asserts.
- Locked at 11, then one period of 13 injected:
  - `meas_valid` with `ratio_x2`=13 and `locked`→0 in the same cycle.
  - Relock after 4 further periods of 11.
- Hold `clk_div` low for 120 cycles (240 half-cycles ≥ 200):
  - `stalled`=1, `locked`=0, outputs hold 11.
  - On restart, the first rise clears `stalled` with no pulse; the second rise pulses `meas_valid` with `ratio_x2`=11.
- Assert `rst_n`=0 mid-period: all outputs 0 asynchronously. After release, the first rise produces no pulse and the second yields a correct value.

Source files
------------

// File: rtl/half_div_meter_if.sv
// Result bundle of the divided-clock meter: measured period/high time plus status flags.
// The meter drives it as master; any consumer attaches through the slave modport.
interface half_div_meter_if #(
  parameter int W = 8
);
  logic [W-1:0] ratio_x2;
  logic [W-1:0] high_x2;
  logic         meas_valid;
  logic         locked;
  logic         stalled;

  modport master (output ratio_x2, high_x2, meas_valid, locked, stalled);
  modport slave  (input  ratio_x2, high_x2, meas_valid, locked, stalled);
endinterface

// File: rtl/half_div_meter.sv
// Measures period and high time of a clk_in-derived divided clock in clk_in half-cycles,
// with lock (stable period) and stall (no rising edge) indication.
module half_div_meter #(
  parameter int W        = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 200
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              clk_div,
  half_div_meter_if.master  mif
);

  localparam logic [W-1:0] CNT_MAX   = '1;
  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
  localparam logic [3:0]   LOCK_MAX  = 4'(LOCK_CNT - 1);

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [1:0] inc);
    logic [W:0] sum;
    sum = {1'b0, a} + {{(W-1){1'b0}}, inc};
    return sum[W] ? CNT_MAX : sum[W-1:0];
  endfunction

  logic         s_neg_q;
  logic         s_pos_q;
  logic [W-1:0] cnt_q,       cnt_d;
  logic [W-1:0] high_hold_q, high_hold_d;
  logic         armed_q,     armed_d;
  logic         vld_p0_q,    vld_p0_d;
  logic [W-1:0] period_p0_q, period_p0_d;
  logic [W-1:0] high_p0_q,   high_p0_d;
  logic [W-1:0] ratio_q,     ratio_d;
  logic [W-1:0] high_q,      high_d;
  logic         meas_q,      meas_d;
  logic         locked_q,    locked_d;
  logic         stalled_q,   stalled_d;
  logic [3:0]   match_q,     match_d;
  logic         prev_vld_q,  prev_vld_d;

  logic rise_a, rise_b, fall_a, fall_b, rise, stall_now;

  // Half-sample taken between posedges; the posedge half-sample is read straight off clk_div.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) s_neg_q <= 1'b0;
    else        s_neg_q <= clk_div;
  end

  // Triple ordering: p = s_pos_q (oldest), a = s_neg_q, b = clk_div (newest)
  always_comb begin
    rise_a    = ~s_pos_q &  s_neg_q;
    rise_b    = ~s_neg_q &  clk_div;
    fall_a    =  s_pos_q & ~s_neg_q;
    fall_b    =  s_neg_q & ~clk_div;
    rise      = rise_a | rise_b;
    stall_now = (cnt_q >= TIMEOUT_W);
  end

  always_comb begin
    cnt_d       = cnt_q;
    high_hold_d = high_hold_q;
    armed_d     = armed_q;
    vld_p0_d    = 1'b0;
    period_p0_d = period_p0_q;
    high_p0_d   = high_p0_q;
    ratio_d     = ratio_q;
    high_d      = high_q;
    meas_d      = 1'b0;
    locked_d    = locked_q;
    stalled_d   = stalled_q;
    match_d     = match_q;
    prev_vld_d  = prev_vld_q;

    // Stage p0: edge detection, half-cycle counting, measurement capture
    if (rise_a)      cnt_d = W'(1);
    else if (rise_b) cnt_d = '0;
    else             cnt_d = sat_add(cnt_q, 2'd2);

    // A fall at b after a rise at a belongs to the new pulse, which is one half-cycle old.
    if (fall_a)      high_hold_d = sat_add(cnt_q, 2'd1);
    else if (fall_b) high_hold_d = rise_a ? W'(1) : sat_add(cnt_q, 2'd2);

    if (rise) begin
      armed_d     = 1'b1;
      stalled_d   = 1'b0;
      period_p0_d = rise_a ? sat_add(cnt_q, 2'd1) : sat_add(cnt_q, 2'd2);
      high_p0_d   = fall_a ? sat_add(cnt_q, 2'd1) : high_hold_q;
      if (armed_q && !stall_now) begin
        vld_p0_d = 1'b1;
      end else if (stall_now) begin
        locked_d   = 1'b0;
        match_d    = '0;
        prev_vld_d = 1'b0;
      end
    end else if (stall_now) begin
      stalled_d  = 1'b1;
      armed_d    = 1'b0;
      locked_d   = 1'b0;
      match_d    = '0;
      prev_vld_d = 1'b0;
    end

    // Stage p1: publish measurement and update lock tracking
    if (vld_p0_q) begin
      ratio_d    = period_p0_q;
      high_d     = high_p0_q;
      meas_d     = 1'b1;
      prev_vld_d = 1'b1;
      if (prev_vld_q && (period_p0_q == ratio_q))
        match_d = (match_q == LOCK_MAX) ? match_q : 4'(match_q + 4'd1);
      else
        match_d = '0;
      locked_d = (match_d == LOCK_MAX);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s_pos_q     <= 1'b0;
      cnt_q       <= '0;
      high_hold_q <= '0;
      armed_q     <= 1'b0;
      vld_p0_q    <= 1'b0;
      period_p0_q <= '0;
      high_p0_q   <= '0;
      ratio_q     <= '0;
      high_q      <= '0;
      meas_q      <= 1'b0;
      locked_q    <= 1'b0;
      stalled_q   <= 1'b0;
      match_q     <= '0;
      prev_vld_q  <= 1'b0;
    end else begin
      s_pos_q     <= clk_div;
      cnt_q       <= cnt_d;
      high_hold_q <= high_hold_d;
      armed_q     <= armed_d;
      vld_p0_q    <= vld_p0_d;
      period_p0_q <= period_p0_d;
      high_p0_q   <= high_p0_d;
      ratio_q     <= ratio_d;
      high_q      <= high_d;
      meas_q      <= meas_d;
      locked_q    <= locked_d;
      stalled_q   <= stalled_d;
      match_q     <= match_d;
      prev_vld_q  <= prev_vld_d;
    end
  end

  assign mif.ratio_x2   = ratio_q;
  assign mif.high_x2    = high_q;
  assign mif.meas_valid = meas_q;
  assign mif.locked     = locked_q;
  assign mif.stalled    = stalled_q;

endmodule

// File: tb/tb_half_div_meter.sv
// Directed bench for half_div_meter: drives clk_div in half-cycle slots and checks
// each measurement pulse against a scoreboard filled by a half-cycle-level model.
module tb_half_div_meter;
  localparam int W    = 8;
  localparam int LOCK = 4;

  logic clk_in  = 1'b0;
  logic rst_n   = 1'b1;
  logic clk_div = 1'b0;

  half_div_meter_if #(.W(W)) mif ();

  half_div_meter #(.W(W), .LOCK_CNT(LOCK), .TIMEOUT(200)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .clk_div (clk_div),
    .mif     (mif)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int ratio;
    int high;
    bit locked;
    int gap;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  bit m_armed = 0, m_prev_vld = 0, m_last_pushed = 0;
  int m_prev_len = 0, m_prev_high = 0, m_last_ratio = 0, m_match = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each call sets the value clk_div shows at the next clk_in edge.
  task automatic half(input bit v);
    @(posedge clk_in or negedge clk_in);
    #1 clk_div = v;
  endtask

  // One clk_div period; its opening rise completes the previous period's measurement.
  task automatic period(input int len, input int hi);
    if (m_armed) begin
      exp_t e;
      if (m_prev_vld && m_prev_len == m_last_ratio) m_match = (m_match == LOCK-1) ? m_match : m_match + 1;
      else m_match = 0;
      e.ratio  = m_prev_len;
      e.high   = m_prev_high;
      e.locked = (m_match == LOCK-1);
      e.gap    = (m_last_pushed && (m_prev_len % 2 == 0)) ? m_prev_len / 2 : 0;
      sb.push_back(e);
      m_last_ratio  = m_prev_len;
      m_prev_vld    = 1;
      m_last_pushed = 1;
    end else begin
      m_last_pushed = 0;
    end
    m_armed     = 1;
    m_prev_len  = len;
    m_prev_high = hi;
    for (int i = 0; i < len; i++) half(i < hi);
  endtask

  task automatic model_abort();
    m_armed       = 0;
    m_prev_vld    = 0;
    m_match       = 0;
    m_last_pushed = 0;
  endtask

  task automatic check_outputs(input string tag, input int ratio, input int high,
                               input bit mv, input bit lk, input bit st);
    check({tag, "_ratio"},   32'(mif.ratio_x2),   32'(ratio));
    check({tag, "_high"},    32'(mif.high_x2),    32'(high));
    check({tag, "_meas"},    32'(mif.meas_valid), 32'(mv));
    check({tag, "_locked"},  32'(mif.locked),     32'(lk));
    check({tag, "_stalled"}, 32'(mif.stalled),    32'(st));
  endtask

  // Measurement monitor, sampling just after each posedge
  initial begin
    int last_pulse;
    exp_t e;
    last_pulse = -1;
    forever begin
      @(posedge clk_in);
      #2;
      if (mif.meas_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_meas_valid", 32'(mif.meas_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          check("meas_ratio",  32'(mif.ratio_x2), 32'(e.ratio));
          check("meas_high",   32'(mif.high_x2),  32'(e.high));
          check("meas_locked", 32'(mif.locked),   32'(e.locked));
          if (e.gap != 0) check("meas_gap", 32'(cyc - last_pulse), 32'(e.gap));
        end
        last_pulse = cyc;
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #20;
    check_outputs("reset", 0, 0, 0, 0, 0);
    @(negedge clk_in);
    #2 rst_n = 1'b1;
    repeat (3) half(1'b0);

    // Divide 5.5, then a 13 glitch and relock at 11
    repeat (8) period(11, 2);
    check("lock_5p5", 32'(mif.locked), 32'(1));
    period(13, 2);
    repeat (5) period(11, 2);
    check("relock_11", 32'(mif.locked), 32'(1));

    // Divide 4 at 50% duty, then divide 1
    repeat (8) period(8, 4);
    check("lock_div4", 32'(mif.locked), 32'(1));
    repeat (8) period(2, 1);
    check("lock_div1", 32'(mif.locked), 32'(1));
    repeat (6) period(11, 2);

    // Stall: clk_div held low for 240 half-cycles
    repeat (240) half(1'b0);
    model_abort();
    check_outputs("stall", 11, 2, 0, 0, 1);
    period(11, 2);
    check("stall_cleared", 32'(mif.stalled), 32'(0));
    repeat (3) period(11, 2);

    // Asynchronous reset in the middle of a period
    repeat (2) half(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 0, 0, 0, 0, 0);
    model_abort();
    #3 rst_n = 1'b1;
    repeat (3) period(11, 2);

    repeat (10) @(posedge clk_in);
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
